// File: rtl/m_bus_pkg.sv
// Shared definitions for the nibble packer: default widths, the fill-side
// state type and a helper that sizes a 0..n counter.
package m_bus_pkg;

    localparam int NIB_W_DEF   = 4;
    localparam int NUM_NIB_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // Width needed to hold any value from 0 up to and including n.
    function automatic int clog2p1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/m_nibble_shift.sv
// Accumulator for the nibble packer. Places each accepted nibble at its
// left-aligned slot, tracks how many nibbles are held, and reports when a
// word (full or flushed) should leave for the output register.
module m_nibble_shift
    import m_bus_pkg::*;
#(
    parameter int NIB_W   = NIB_W_DEF,
    parameter int NUM_NIB = NUM_NIB_DEF,
    localparam int CW     = clog2p1(NUM_NIB),
    localparam int WW     = NIB_W * NUM_NIB
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept,
    input  logic             take_flush,
    input  logic [NIB_W-1:0] in_data,
    output logic             emit,
    output logic [WW-1:0]    emit_word,
    output logic [CW-1:0]    emit_count
);

    fill_state_t     state;
    fill_state_t     state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic [CW-1:0]   cnt_inc;
    logic [WW-1:0]   acc;
    logic [WW-1:0]   acc_next;
    logic [WW-1:0]   merged;
    logic            done;

    // Word as it would look including this cycle's nibble, and emit decision.
    always_comb begin
        merged = acc;
        for (int i = 0; i < NUM_NIB; i++) begin
            if (accept && (cnt == CW'(i))) begin
                merged[NIB_W*(NUM_NIB-1-i) +: NIB_W] = in_data;
            end
        end
        cnt_inc    = cnt + CW'(accept);
        done       = accept && (cnt == CW'(NUM_NIB - 1));
        emit       = done || (take_flush && (cnt_inc != '0));
        emit_word  = merged;
        emit_count = cnt_inc;
    end

    // Fill-side next state: emitting always empties the accumulator.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        acc_next   = acc;
        case (state)
            IDLE, FILL: begin
                if (emit) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    acc_next   = '0;
                end else if (accept) begin
                    state_next = FILL;
                    cnt_next   = cnt_inc;
                    acc_next   = merged;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                acc_next   = '0;
            end
        endcase
    end

    // Accumulator registers; reset discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            acc   <= acc_next;
        end
    end

endmodule

// File: rtl/m_nibble_packer.sv
// Nibble packer top: valid/ready input, accumulator, and a one-entry output
// register. Optional feature macro: PACKER_PARITY_EN adds a registered
// out_parity (XOR of the emitted word, padding included).
module m_nibble_packer
    import m_bus_pkg::*;
#(
    parameter int NIB_W   = NIB_W_DEF,
    parameter int NUM_NIB = NUM_NIB_DEF,
    localparam int CW     = clog2p1(NUM_NIB),
    localparam int WW     = NIB_W * NUM_NIB
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NIB_W-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WW-1:0]    out_data,
    output logic [CW-1:0]    out_count
`ifdef PACKER_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    logic          accept;
    logic          take_flush;
    logic          emit;
    logic [WW-1:0] emit_word;
    logic [CW-1:0] emit_count;

    // Ready whenever the output slot is free or being drained this cycle.
    always_comb begin
        in_ready   = !out_valid || out_ready;
        accept     = in_valid && in_ready;
        take_flush = flush && in_ready;
    end

    m_nibble_shift #(
        .NIB_W   (NIB_W),
        .NUM_NIB (NUM_NIB)
    ) u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept     (accept),
        .take_flush (take_flush),
        .in_data    (in_data),
        .emit       (emit),
        .emit_word  (emit_word),
        .emit_count (emit_count)
    );

    // Output register: load on emit (may replace a draining word), else drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_count  <= '0;
`ifdef PACKER_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else if (emit) begin
            out_valid  <= 1'b1;
            out_data   <= emit_word;
            out_count  <= emit_count;
`ifdef PACKER_PARITY_EN
            out_parity <= ^emit_word;
`endif
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_m_nibble_packer.sv
// Self-checking bench for m_nibble_packer: directed scenarios plus a random
// run, all compared against a queue-based behavioural model.
module tb_m_nibble_packer;
    import m_bus_pkg::*;

    localparam int NIB_W   = 4;
    localparam int NUM_NIB = 4;
    localparam int CW      = $clog2(NUM_NIB + 1);
    localparam int WW      = NIB_W * NUM_NIB;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NIB_W-1:0] in_data = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WW-1:0]    out_data;
    logic [CW-1:0]    out_count;
`ifdef PACKER_PARITY_EN
    logic             out_parity;
`endif

    m_nibble_packer #(.NIB_W(NIB_W), .NUM_NIB(NUM_NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
`ifdef PACKER_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: nibbles held so far, plus the output slot.
    logic [NIB_W-1:0] nibs[$];
    bit               m_valid;
    logic [WW-1:0]    m_data;
    int               m_count;
    bit               obs_ready;
    bit               exp_ready;
    int               n_checks;
    int               n_fail;

    function automatic logic [WW-1:0] pack_nibs();
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < nibs.size(); i++)
            w = w | (WW'(nibs[i]) << (NIB_W * (NUM_NIB - 1 - i)));
        return w;
    endfunction

    // Drive one cycle of inputs, sample in_ready before the edge, advance the model.
    task automatic cycle(input bit v, input logic [NIB_W-1:0] d, input bit f, input bit r);
        bit rdy;
        bit emit;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        #1;
        obs_ready = in_ready;
        rdy       = !m_valid || r;
        exp_ready = rdy;
        @(posedge clk);
        if (v && rdy) nibs.push_back(d);
        emit = (nibs.size() == NUM_NIB) || (f && rdy && nibs.size() > 0);
        if (emit) begin
            m_valid = 1'b1;
            m_data  = pack_nibs();
            m_count = nibs.size();
            nibs.delete();
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_count !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_state: valid=%0b data=%h count=%0d ready=%0b, required 0/0000/0/1",
                     out_valid, out_data, out_count, in_ready);
        end
`ifdef PACKER_PARITY_EN
        n_checks++;
        if (out_parity !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_parity: got %0b required 0", out_parity);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        nibs.delete();
        m_valid = 1'b0;
    endtask

    task automatic test_pack();
        logic [NIB_W-1:0] seq [4] = '{4'b1010, 4'b1100, 4'b1101, 4'b0001};
        for (int i = 0; i < 4; i++) cycle(1'b1, seq[i], 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hACD1 || out_count !== CW'(4)) begin
            n_fail++;
            $display("[TB] FAIL pack_word: valid=%0b data=%h count=%0d, required 1/acd1/4",
                     out_valid, out_data, out_count);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL pack_one_cycle: valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int words = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(i < 8, 4'b1101, 1'b0, 1'b1);
            n_checks++;
            if (obs_ready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL b2b_ready cycle %0d: got %0b required 1", i, obs_ready);
            end
            if (out_valid === 1'b1 && out_data === 16'hDDDD && out_count === CW'(4)) words++;
        end
        n_checks++;
        if (words != 2) begin
            n_fail++;
            $display("[TB] FAIL b2b_words: got %0d words required 2", words);
        end
    endtask

    task automatic test_backpressure();
        logic [NIB_W-1:0] seq [4] = '{4'h5, 4'h6, 4'h7, 4'h8};
        for (int i = 0; i < 4; i++) cycle(1'b1, seq[i], 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 4'b0011, 1'b0, 1'b0);
            n_checks++;
            if (obs_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h5678) begin
                n_fail++;
                $display("[TB] FAIL bp_stall: ready=%0b valid=%0b data=%h, required 0/1/5678",
                         obs_ready, out_valid, out_data);
            end
        end
        cycle(1'b1, 4'b0011, 1'b0, 1'b1);
        n_checks++;
        if (obs_ready !== 1'b1 || out_valid !== 1'b0 || nibs.size() != 1) begin
            n_fail++;
            $display("[TB] FAIL bp_drain: ready=%0b valid=%0b, required 1/0", obs_ready, out_valid);
        end
        cycle(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h3000 || out_count !== CW'(1)) begin
            n_fail++;
            $display("[TB] FAIL bp_accepted: valid=%0b data=%h count=%0d, required 1/3000/1",
                     out_valid, out_data, out_count);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        logic [NIB_W-1:0] seq [3] = '{4'b1010, 4'b1100, 4'b1110};
        for (int i = 0; i < 3; i++) cycle(1'b1, seq[i], 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hACE0 || out_count !== CW'(3)) begin
            n_fail++;
            $display("[TB] FAIL flush_partial: valid=%0b data=%h count=%0d, required 1/ace0/3",
                     out_valid, out_data, out_count);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_empty: valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_mid_reset();
        logic [NIB_W-1:0] seq [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        cycle(1'b1, 4'h9, 1'b0, 1'b1);
        cycle(1'b1, 4'h9, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_count !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midreset_state: valid=%0b data=%h count=%0d ready=%0b, required 0/0000/0/1",
                     out_valid, out_data, out_count, in_ready);
        end
        nibs.delete();
        m_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b1, seq[i], 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_count !== CW'(4)) begin
            n_fail++;
            $display("[TB] FAIL midreset_word: valid=%0b data=%h count=%0d, required 1/1234/4",
                     out_valid, out_data, out_count);
        end
`ifdef PACKER_PARITY_EN
        n_checks++;
        if (out_parity !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL parity_1234: got %0b required 1", out_parity);
        end
        cycle(1'b1, 4'b1010, 1'b1, 1'b1);
        n_checks++;
        if (out_data !== 16'hA000 || out_parity !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL parity_a000: data=%h parity=%0b, required a000/0", out_data, out_parity);
        end
`endif
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, NIB_W'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) != 0);
            n_checks++;
            if (obs_ready !== exp_ready || out_valid !== m_valid) begin
                n_fail++;
                $display("[TB] FAIL rand_ctrl cycle %0d: ready=%0b valid=%0b, required %0b/%0b",
                         i, obs_ready, out_valid, exp_ready, m_valid);
            end
            if (m_valid) begin
                n_checks++;
                if (out_data !== m_data || out_count !== CW'(m_count)) begin
                    n_fail++;
                    $display("[TB] FAIL rand_word cycle %0d: data=%h count=%0d, required %h/%0d",
                             i, out_data, out_count, m_data, m_count);
                end
`ifdef PACKER_PARITY_EN
                n_checks++;
                if (out_parity !== ^m_data) begin
                    n_fail++;
                    $display("[TB] FAIL rand_parity cycle %0d: got %0b required %0b",
                             i, out_parity, ^m_data);
                end
`endif
            end
        end
    endtask

    // Run the scenarios in order, then report.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_valid  = 1'b0;
        m_data   = '0;
        m_count  = 0;
        test_reset();
        test_pack();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
